// File: rtl/conv_pe_scheduler.sv
// conv_pe_scheduler: sequences weight load, window issue and drain for a systolic 3x3x3 conv PE chain
module conv_pe_scheduler #(
    parameter int IMG_W          = 16,
    parameter int IMG_H          = 16,
    parameter int NUM_OF_FILTERS = 16,
    parameter int PE_LATENCY     = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic                              stall_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              wload_valid_o,
    output logic [$clog2(NUM_OF_FILTERS)-1:0] wload_idx_o,
    output logic                              win_valid_o,
    output logic [$clog2(IMG_H)-1:0]          win_row_o,
    output logic [$clog2(IMG_W)-1:0]          win_col_o,
    output logic                              out_valid_o,
    output logic [$clog2(IMG_H)-1:0]          out_row_o,
    output logic [$clog2(IMG_W)-1:0]          out_col_o
);
    localparam int IW      = $clog2(NUM_OF_FILTERS);
    localparam int RW      = $clog2(IMG_H);
    localparam int CW      = $clog2(IMG_W);
    localparam int DW      = 1 + RW + CW;
    localparam int DRAIN_N = PE_LATENCY + NUM_OF_FILTERS - 1;
    localparam int DCW     = $clog2(DRAIN_N + 1);
    localparam logic [IW-1:0]  IDX_LAST   = IW'(NUM_OF_FILTERS - 1);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(IMG_H - 3);
    localparam logic [CW-1:0]  COL_LAST   = CW'(IMG_W - 3);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_N - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [DW-1:0]  dl_q [PE_LATENCY];
    logic [DW-1:0]  dl_d [PE_LATENCY];
    logic           win_last;

    assign win_last = win_valid_o && row_q == ROW_LAST && col_q == COL_LAST;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? LOAD_W : IDLE;
            LOAD_W:  state_d = (idx_q == IDX_LAST) ? STREAM : LOAD_W;
            STREAM:  state_d = win_last ? DRAIN : STREAM;
            DRAIN:   state_d = (dcnt_q == DRAIN_LAST) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o        = state_q != IDLE;
        done_o        = state_q == DONE;
        wload_valid_o = state_q == LOAD_W;
        wload_idx_o   = wload_valid_o ? idx_q : '0;
        win_valid_o   = state_q == STREAM && !stall_i;
        win_row_o     = win_valid_o ? row_q : '0;
        win_col_o     = win_valid_o ? col_q : '0;
        {out_valid_o, out_row_o, out_col_o} = dl_q[PE_LATENCY-1];
    end

    // Counters wrap to zero on their last value so the next pass starts clean.
    always_comb begin
        idx_d  = (state_q == LOAD_W) ? ((idx_q == IDX_LAST) ? '0 : idx_q + IW'(1)) : idx_q;
        col_d  = win_valid_o ? ((col_q == COL_LAST) ? '0 : col_q + CW'(1)) : col_q;
        row_d  = (win_valid_o && col_q == COL_LAST) ? ((row_q == ROW_LAST) ? '0 : row_q + RW'(1)) : row_q;
        dcnt_d = (state_q == DRAIN) ? ((dcnt_q == DRAIN_LAST) ? '0 : dcnt_q + DCW'(1)) : dcnt_q;
        dl_d[0] = {win_valid_o, win_row_o, win_col_o};
        for (int i = 1; i < PE_LATENCY; i++) dl_d[i] = dl_q[i-1];
    end

    // The delay line shifts unconditionally: the PEs have no enable to stall on.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            dcnt_q <= '0;
            for (int i = 0; i < PE_LATENCY; i++) dl_q[i] <= '0;
        end else begin
            idx_q  <= idx_d;
            row_q  <= row_d;
            col_q  <= col_d;
            dcnt_q <= dcnt_d;
            dl_q   <= dl_d;
        end
    end
endmodule

// File: doc/conv_pe_scheduler.md
Name: conv_pe_scheduler

Overview:
- Sequences one 3x3x3 convolution pass over an IMG_W x IMG_H RGB feature map through a systolic chain of NUM_OF_FILTERS PEs.
- The PEs forward the 216-bit window downstream each cycle and hold fixed weights.
- The block runs three phases: weight load (one slot per PE), row-major window issue with back-pressure, and a pipeline drain.
- It produces valid/coordinate side-band for results and a completion pulse.
- It sits between the line-buffer/window generator, the weight ROM and the PE chain.

Parameters:
- IMG_W, 16, input map width in pixels (>=3).
- IMG_H, 16, input map height in pixels (>=3).
- NUM_OF_FILTERS, 16, PEs in the chain, one filter per PE.
- PE_LATENCY, 2, cycles from window presented at PE0 to PE0 out_c valid.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  pulse: begin a pass; ignored unless IDLE.
- stall_i  in  1  downstream output buffer almost full; suppresses new window issue.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the pass completes.
- wload_valid_o  out  1  weight-load strobe for the PE addressed by wload_idx_o.
- wload_idx_o  out  $clog2(NUM_OF_FILTERS)  PE/filter index being loaded, also the weight ROM address.
- win_valid_o  out  1  window generator must drive the window at (win_row_o, win_col_o) into PE0 in_a this cycle.
- win_row_o  out  $clog2(IMG_H)  top-left row of the issued window.
- win_col_o  out  $clog2(IMG_W)  top-left column of the issued window.
- out_valid_o  out  1  PE0 out_c holds the result for (out_row_o, out_col_o).
- out_row_o  out  $clog2(IMG_H)  result row.
- out_col_o  out  $clog2(IMG_W)  result column.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; all counters and the delay line cleared. This applies mid-pass too: the pass is abandoned and no done_o is produced.
- Output grid: OUT_W = IMG_W-2, OUT_H = IMG_H-2 (stride 1, no padding). Windows total OUT_W*OUT_H.
- FSM: IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: start_i=1 moves to LOAD_W next cycle.
- LOAD_W: wload_valid_o=1 for exactly NUM_OF_FILTERS consecutive cycles. wload_idx_o runs 0..NUM_OF_FILTERS-1. stall_i has no effect. After idx NUM_OF_FILTERS-1 -> STREAM.
- STREAM: each cycle with stall_i=0, issue one window: win_valid_o=1 with the current (row,col).
  - col advances 0..OUT_W-1, then wraps to 0 and row increments.
  - With stall_i=1: win_valid_o=0 and coordinates hold.
  - After window (OUT_H-1, OUT_W-1) is issued -> DRAIN.
- DRAIN: counts PE_LATENCY+NUM_OF_FILTERS-1 cycles so the last PE's result emerges. stall_i is ignored. Then -> DONE.
- DONE: done_o=1 for one cycle; busy_o still 1; -> IDLE. busy_o drops the cycle after done_o.
- Result tracking: win_valid_o/row/col enter a PE_LATENCY-deep register delay line that reproduces them as out_valid_o/out_row_o/out_col_o.
  - This is exactly PE_LATENCY cycles after issue, for PE0.
  - Downstream derives PE k timing as +k cycles.
  - The delay line shifts every cycle regardless of stall_i, because the PEs have no enable.
- Back-pressure contract: in-flight windows still complete after stall_i rises. The downstream buffer asserts stall_i with at least PE_LATENCY+NUM_OF_FILTERS-1 free slots.
- start_i during busy_o=1: ignored, with no effect on counters.
- A start_i in the same cycle as done_o is ignored; a new pass needs start_i in IDLE.
- Width rules: counters compare against OUT_W-1 and OUT_H-1 exactly, with no overflow wrap. Coordinate outputs are zero when the matching valid is 0.

Test Plan:
- Basic pass, IMG_W=IMG_H=5, NUM_OF_FILTERS=16, PE_LATENCY=2: start_i pulse -> wload_valid_o for 16 cycles (idx 0..15), then 9 consecutive win_valid_o with (r,c) = (0,0),(0,1),(0,2),(1,0)...(2,2). Then a 17-cycle drain, then a single done_o; busy_o high from the cycle after start through done.
- Result timing, same config: each win_valid_o at cycle t -> out_valid_o at t+2 with identical row/col; exactly 9 out_valid_o pulses total.
- Stall: hold stall_i=1 for 3 cycles after the 4th window -> windows 5..9 are delayed by 3 cycles with no coordinate skipped or repeated. out_valid_o continues for windows already issued; window count stays 9.
- Stall in LOAD_W and DRAIN: stall_i=1 throughout those phases -> no change from the basic-pass timing.
- Async reset mid-STREAM after window 4: rst_n=0 -> all outputs 0 immediately, no done_o. After release, start_i -> a full fresh pass from idx 0 and window (0,0).
- start_i re-pulsed during STREAM and on the done_o cycle -> ignored; exactly one pass and one done_o observed.
